// File: rtl/snn_pkg.sv
// Shared types and helpers for the SNN layer sequencer and its RAM port mux.
package snn_pkg;

    localparam int SNN_ADDR_W = 12;
    localparam int SNN_DATA_W = 16;
    localparam int MAX_STAGES = 8;
    // One bit wider than a stage index so the scan can step past the last stage.
    localparam int IDX_W      = 4;
    localparam int SEL_W      = 3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SEL    = 3'd1,
        ACTIVE = 3'd2,
        GAP    = 3'd3,
        DONE   = 3'd4
    } seq_state_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } stage_sel_t;

    // Lowest enabled stage at or above 'from'.
    function automatic stage_sel_t next_enabled(input logic [MAX_STAGES-1:0] mask,
                                                input logic [IDX_W-1:0]      from);
        stage_sel_t r;
        r.found = 1'b0;
        r.idx   = '0;
        for (int i = MAX_STAGES - 1; i >= 0; i--) begin
            if (mask[i] && (IDX_W'(i) >= from)) begin
                r.found = 1'b1;
                r.idx   = IDX_W'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/snn_layer_sequencer_if.sv
// Shared RAM write port driven by the layer sequencer.
interface snn_layer_sequencer_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
) ();

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;

    modport master (output mem_addr, output mem_wdata, output mem_we);
    modport slave  (input  mem_addr, input  mem_wdata, input  mem_we);

endinterface

// File: rtl/snn_port_mux.sv
// N-to-1 slice mux over a flattened bus; output forced to zero when not enabled.
module snn_port_mux
    import snn_pkg::*;
#(
    parameter int N = 3,
    parameter int W = 12
) (
    input  logic [N*W-1:0]  din,
    input  logic [SEL_W-1:0] sel,
    input  logic             en,
    output logic [W-1:0]     dout
);

    always_comb begin
        dout = '0;
        if (en) begin
            for (int i = 0; i < N; i++) begin
                if (sel == SEL_W'(i)) dout = din[i*W +: W];
            end
        end
    end

endmodule

// File: rtl/snn_layer_sequencer.sv
// Runs N_STAGES layer engines in order and shares one RAM port between them.
// Optional watchdog per stage: define SNN_SEQ_WATCHDOG_EN.
module snn_layer_sequencer
    import snn_pkg::*;
#(
    parameter int ADDR_W      = SNN_ADDR_W,
    parameter int DATA_W      = SNN_DATA_W,
    parameter int N_STAGES    = 3,
    parameter int CNT_W       = 24,
    parameter int WDOG_CYCLES = 65535
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         run,
    input  logic [N_STAGES-1:0]          stage_en,
    output logic                         busy,
    output logic                         done,
    output logic [2:0]                   cur_stage,
    output logic [N_STAGES-1:0]          stage_start,
    input  logic [N_STAGES-1:0]          stage_done,
    input  logic [N_STAGES*ADDR_W-1:0]   stage_addr,
    input  logic [N_STAGES*DATA_W-1:0]   stage_wdata,
    input  logic [N_STAGES-1:0]          stage_we,
    snn_layer_sequencer_if.master        mem,
    output logic [CNT_W-1:0]             run_cycles,
    output logic                         timeout
);

    localparam logic [2:0] ST_IDLE   = 3'(IDLE);
    localparam logic [2:0] ST_SEL    = 3'(SEL);
    localparam logic [2:0] ST_ACTIVE = 3'(ACTIVE);
    localparam logic [2:0] ST_GAP    = 3'(GAP);
    localparam logic [2:0] ST_DONE   = 3'(DONE);

    logic [2:0]          state_q, state_d;
    logic [N_STAGES-1:0] en_q, en_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    cyc_q, cyc_d;
    logic [N_STAGES-1:0] start_vec;
    logic                act_done;
    logic                in_active;
    stage_sel_t          nxt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

`ifdef SNN_SEQ_WATCHDOG_EN
    localparam int             WD_W    = $clog2(WDOG_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYCLES - 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            to_q, to_d;
`endif

    assign in_active = (state_q == ST_ACTIVE);

    always_comb begin
        start_vec = '0;
        for (int i = 0; i < N_STAGES; i++) begin
            if (in_active && (idx_q == IDX_W'(i))) start_vec[i] = 1'b1;
        end
    end

    // Only the active engine's done can advance the sequence.
    assign act_done = |(stage_done & start_vec);

    always_comb begin
        state_d = state_q;
        en_d    = en_q;
        idx_d   = idx_q;
        cyc_d   = cyc_q;
        nxt     = next_enabled(MAX_STAGES'(en_q), idx_q);
        if (state_q != ST_IDLE) cyc_d = sat_inc(cyc_q);
        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    en_d    = stage_en;
                    idx_d   = '0;
                    // The accept cycle itself is the first counted run cycle.
                    cyc_d   = CNT_W'(1);
                    state_d = ST_SEL;
                end
            end
            ST_SEL: begin
                if (nxt.found) begin
                    idx_d   = nxt.idx;
                    state_d = ST_ACTIVE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_ACTIVE: if (act_done) state_d = ST_GAP;
            ST_GAP: begin
                idx_d   = idx_q + IDX_W'(1);
                state_d = ST_SEL;
            end
            ST_DONE: begin
                idx_d   = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
`ifdef SNN_SEQ_WATCHDOG_EN
        wd_d = wd_q;
        to_d = to_q;
        if (state_q == ST_IDLE && run) to_d = 1'b0;
        if (state_q == ST_SEL) wd_d = '0;
        if (in_active && !act_done) begin
            if (wd_q == WD_LAST) begin
                to_d    = 1'b1;
                state_d = ST_DONE;
            end else begin
                wd_d = wd_q + WD_W'(1);
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            en_q    <= '0;
            idx_q   <= '0;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            idx_q   <= idx_d;
            cyc_q   <= cyc_d;
        end
    end

`ifdef SNN_SEQ_WATCHDOG_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_q <= '0;
            to_q <= 1'b0;
        end else begin
            wd_q <= wd_d;
            to_q <= to_d;
        end
    end
    assign timeout = to_q;
`else
    assign timeout = 1'b0;
`endif

    snn_port_mux #(.N(N_STAGES), .W(ADDR_W)) u_addr_mux (
        .din  (stage_addr),
        .sel  (idx_q[SEL_W-1:0]),
        .en   (in_active),
        .dout (mem.mem_addr)
    );

    snn_port_mux #(.N(N_STAGES), .W(DATA_W)) u_wdata_mux (
        .din  (stage_wdata),
        .sel  (idx_q[SEL_W-1:0]),
        .en   (in_active),
        .dout (mem.mem_wdata)
    );

    snn_port_mux #(.N(N_STAGES), .W(1)) u_we_mux (
        .din  (stage_we),
        .sel  (idx_q[SEL_W-1:0]),
        .en   (in_active),
        .dout (mem.mem_we)
    );

    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign cur_stage   = idx_q[2:0];
    assign stage_start = start_vec;
    assign run_cycles  = cyc_q;

endmodule

// File: tb/tb_snn_layer_sequencer.sv
// Directed bench for snn_layer_sequencer with a small engine model (done 5 cycles after start).
module tb_snn_layer_sequencer;

    localparam int N = 3;

    logic           clk = 1'b0;
    logic           reset;
    logic           run;
    logic [N-1:0]   stage_en;
    logic           busy, done, timeout;
    logic [2:0]     cur_stage;
    logic [N-1:0]   stage_start, stage_done, stage_we;
    logic [N*12-1:0] stage_addr;
    logic [N*16-1:0] stage_wdata;
    logic [23:0]    run_cycles;

    logic [N-1:0]   man_done, auto_done;
    logic           auto_en;
    int             eng_cnt [N];

    int vec  = 0;
    int errs = 0;

    snn_layer_sequencer_if #(.ADDR_W(12), .DATA_W(16)) mem_if ();

    snn_layer_sequencer #(
        .ADDR_W(12), .DATA_W(16), .N_STAGES(N), .CNT_W(24), .WDOG_CYCLES(16)
    ) dut (
        .clk(clk), .reset(reset), .run(run), .stage_en(stage_en),
        .busy(busy), .done(done), .cur_stage(cur_stage),
        .stage_start(stage_start), .stage_done(stage_done),
        .stage_addr(stage_addr), .stage_wdata(stage_wdata), .stage_we(stage_we),
        .mem(mem_if.master), .run_cycles(run_cycles), .timeout(timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) eng_cnt[i] <= stage_start[i] ? eng_cnt[i] + 1 : 0;
    end

    always_comb begin
        auto_done = '0;
        for (int j = 0; j < N; j++) auto_done[j] = auto_en && stage_start[j] && (eng_cnt[j] >= 5);
    end

    assign stage_done = auto_done | man_done;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench one step after the accept edge (k = 0).
    task automatic accept_run(input logic [N-1:0] mask);
        run      = 1'b1;
        stage_en = mask;
        cyc();
        run = 1'b0;
    endtask

    task automatic test_reset();
        logic [61:0] snap;
        reset       = 1'b1;
        stage_we    = 3'b111;
        stage_addr  = {12'h3C3, 12'h0A5, 12'h777};
        stage_wdata = {16'hBEEF, 16'h1234, 16'hDEAD};
        cyc();
        cyc();
        snap = {busy, done, stage_start, mem_if.mem_we, mem_if.mem_addr, mem_if.mem_wdata,
                cur_stage, run_cycles, timeout};
        vec++;
        if (snap !== '0) begin
            errs++;
            $display("FAIL reset_state got %h want 0", snap);
        end
        reset = 1'b0;
        cyc();
        vec++;
        if ({busy, done} !== 2'b00) begin
            errs++;
            $display("FAIL idle_after_reset busy/done got %b%b want 00", busy, done);
        end
    endtask

    task automatic test_all_stages();
        logic [2:0] exp_start;
        logic       exp_done, exp_busy;
        auto_en  = 1'b1;
        man_done = '0;
        stage_we = '0;
        accept_run(3'b111);
        for (int k = 0; k <= 30; k++) begin
            exp_start = (k >= 1 && k <= 6)   ? 3'b001 :
                        (k >= 9 && k <= 14)  ? 3'b010 :
                        (k >= 17 && k <= 22) ? 3'b100 : 3'b000;
            exp_done  = (k == 25);
            exp_busy  = (k <= 25);
            vec++;
            if ({busy, done, stage_start} !== {exp_busy, exp_done, exp_start}) begin
                errs++;
                $display("FAIL all_stages k=%0d busy/done/start got %b/%b/%b want %b/%b/%b",
                         k, busy, done, stage_start, exp_busy, exp_done, exp_start);
            end
            if (k == 26 || k == 30) begin
                vec++;
                if (run_cycles !== 24'd27) begin
                    errs++;
                    $display("FAIL run_cycles k=%0d got %0d want 27", k, run_cycles);
                end
            end
            cyc();
        end
        auto_en = 1'b0;
    endtask

    task automatic test_skip_stage();
        logic [2:0] exp_start;
        auto_en = 1'b1;
        accept_run(3'b101);
        for (int k = 0; k <= 19; k++) begin
            exp_start = (k >= 1 && k <= 6)  ? 3'b001 :
                        (k >= 9 && k <= 14) ? 3'b100 : 3'b000;
            vec++;
            if ({done, stage_start} !== {(k == 17), exp_start}) begin
                errs++;
                $display("FAIL skip_stage k=%0d done/start got %b/%b want %b/%b",
                         k, done, stage_start, (k == 17), exp_start);
            end
            if (k == 3 || k == 12) begin
                vec++;
                if (cur_stage !== ((k == 3) ? 3'd0 : 3'd2)) begin
                    errs++;
                    $display("FAIL skip_cur_stage k=%0d got %0d want %0d", k, cur_stage, (k == 3) ? 0 : 2);
                end
            end
            if (k == 18) begin
                vec++;
                if (run_cycles !== 24'd19) begin
                    errs++;
                    $display("FAIL skip_run_cycles got %0d want 19", run_cycles);
                end
            end
            cyc();
        end
        auto_en = 1'b0;
    endtask

    task automatic test_zero_mask();
        logic [5:0] exp [3];
        exp[0] = 6'b1_0_000_0;
        exp[1] = 6'b1_1_000_0;
        exp[2] = 6'b0_0_000_0;
        stage_we = 3'b111;
        accept_run(3'b000);
        for (int k = 0; k < 3; k++) begin
            vec++;
            if ({busy, done, stage_start, mem_if.mem_we} !== exp[k]) begin
                errs++;
                $display("FAIL zero_mask k=%0d busy/done/start/we got %b want %b",
                         k, {busy, done, stage_start, mem_if.mem_we}, exp[k]);
            end
            if (k < 2) cyc();
        end
        vec++;
        if (run_cycles !== 24'd3) begin
            errs++;
            $display("FAIL zero_run_cycles got %0d want 3", run_cycles);
        end
        cyc();
    endtask

    task automatic test_mux();
        auto_en  = 1'b0;
        stage_we = 3'b111;
        accept_run(3'b010);
        vec++;
        if ({mem_if.mem_we, mem_if.mem_addr, mem_if.mem_wdata} !== 29'd0) begin
            errs++;
            $display("FAIL mux_sel_zero got %b/%h/%h want 0/000/0000",
                     mem_if.mem_we, mem_if.mem_addr, mem_if.mem_wdata);
        end
        cyc();
        vec++;
        if ({cur_stage, stage_start, mem_if.mem_we, mem_if.mem_addr, mem_if.mem_wdata}
            !== {3'd1, 3'b010, 1'b1, 12'h0A5, 16'h1234}) begin
            errs++;
            $display("FAIL mux_stage1 got cur=%0d start=%b we=%b addr=%h wdata=%h want 1/010/1/0a5/1234",
                     cur_stage, stage_start, mem_if.mem_we, mem_if.mem_addr, mem_if.mem_wdata);
        end
        stage_we = 3'b101;
        #1;
        vec++;
        if ({mem_if.mem_we, mem_if.mem_addr, mem_if.mem_wdata} !== {1'b0, 12'h0A5, 16'h1234}) begin
            errs++;
            $display("FAIL mux_we_follow got %b/%h/%h want 0/0a5/1234",
                     mem_if.mem_we, mem_if.mem_addr, mem_if.mem_wdata);
        end
        man_done = 3'b010;
        cyc();
        man_done = '0;
        stage_we = 3'b111;
        vec++;
        if ({busy, stage_start, mem_if.mem_we, mem_if.mem_addr, mem_if.mem_wdata}
            !== {1'b1, 3'b000, 1'b0, 12'h000, 16'h0000}) begin
            errs++;
            $display("FAIL mux_gap got busy=%b start=%b we=%b addr=%h wdata=%h want 1/000/0/000/0000",
                     busy, stage_start, mem_if.mem_we, mem_if.mem_addr, mem_if.mem_wdata);
        end
        cyc();
        cyc();
        vec++;
        if (done !== 1'b1) begin
            errs++;
            $display("FAIL mux_done got %b want 1", done);
        end
        cyc();
        stage_we = '0;
    endtask

    task automatic test_spurious();
        int done_cnt = 0;
        int first    = -1;
        auto_en  = 1'b0;
        man_done = 3'b111;
        accept_run(3'b111);
        cyc();
        man_done = 3'b100;
        run      = 1'b1;
        stage_en = 3'b000;
        vec++;
        if (stage_start !== 3'b001) begin
            errs++;
            $display("FAIL spurious_first_start got %b want 001", stage_start);
        end
        for (int k = 2; k <= 5; k++) begin
            cyc();
            vec++;
            if ({busy, done, stage_start, cur_stage} !== {1'b1, 1'b0, 3'b001, 3'd0}) begin
                errs++;
                $display("FAIL spurious_hold k=%0d busy/done/start/cur got %b/%b/%b/%0d want 1/0/001/0",
                         k, busy, done, stage_start, cur_stage);
            end
        end
        run      = 1'b0;
        man_done = 3'b001;
        cyc();
        man_done = '0;
        auto_en  = 1'b1;
        for (int k = 6; k <= 40; k++) begin
            if (done) begin
                done_cnt++;
                if (first < 0) first = k;
            end
            if (k == 8) begin
                vec++;
                if (stage_start !== 3'b010) begin
                    errs++;
                    $display("FAIL spurious_mask_latched got %b want 010", stage_start);
                end
            end
            cyc();
        end
        vec++;
        if (done_cnt !== 1 || first !== 24) begin
            errs++;
            $display("FAIL spurious_done_count got %0d at k=%0d want 1 at k=24", done_cnt, first);
        end
        auto_en = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        logic [61:0] snap;
        stage_we = 3'b111;
        accept_run(3'b111);
        cyc();
        vec++;
        if ({stage_start, mem_if.mem_we, mem_if.mem_addr} !== {3'b001, 1'b1, 12'h777}) begin
            errs++;
            $display("FAIL midrun_active got start=%b we=%b addr=%h want 001/1/777",
                     stage_start, mem_if.mem_we, mem_if.mem_addr);
        end
        man_done = 3'b001;
        reset    = 1'b1;
        cyc();
        snap = {busy, done, stage_start, mem_if.mem_we, mem_if.mem_addr, mem_if.mem_wdata,
                cur_stage, run_cycles, timeout};
        vec++;
        if (snap !== '0) begin
            errs++;
            $display("FAIL midrun_reset got %h want 0", snap);
        end
        reset    = 1'b0;
        man_done = '0;
        cyc();
        vec++;
        if ({busy, stage_start} !== 4'b0000) begin
            errs++;
            $display("FAIL reset_beats_done busy/start got %b/%b want 0/000", busy, stage_start);
        end
        stage_we = '0;
    endtask

    task automatic test_watchdog();
        int   first    = -1;
        logic to_at    = 1'b0;
        logic [2:0] st_at = 3'b111;
        auto_en  = 1'b0;
        man_done = '0;
        accept_run(3'b001);
`ifdef SNN_SEQ_WATCHDOG_EN
        for (int k = 0; k <= 40; k++) begin
            if (done && first < 0) begin
                first = k;
                to_at = timeout;
                st_at = stage_start;
            end
            cyc();
        end
        vec++;
        if (first !== 17 || to_at !== 1'b1 || st_at !== 3'b000) begin
            errs++;
            $display("FAIL watchdog done at k=%0d timeout=%b start=%b want k=17 timeout=1 start=000",
                     first, to_at, st_at);
        end
        vec++;
        if ({busy, timeout} !== 2'b01) begin
            errs++;
            $display("FAIL watchdog_sticky busy/timeout got %b%b want 01", busy, timeout);
        end
        accept_run(3'b000);
        vec++;
        if (timeout !== 1'b0) begin
            errs++;
            $display("FAIL watchdog_clear got %b want 0", timeout);
        end
        cyc();
        cyc();
`else
        for (int k = 0; k < 40; k++) cyc();
        vec++;
        if ({busy, stage_start, timeout} !== {1'b1, 3'b001, 1'b0}) begin
            errs++;
            $display("FAIL no_watchdog_wait busy/start/timeout got %b/%b/%b want 1/001/0",
                     busy, stage_start, timeout);
        end
        man_done = 3'b001;
        cyc();
        man_done = '0;
        for (int k = 0; k < 10; k++) begin
            if (done && first < 0) first = k;
            cyc();
        end
        vec++;
        if (first !== 2) begin
            errs++;
            $display("FAIL no_watchdog_finish done at %0d want 2", first);
        end
`endif
    endtask

    initial begin
        reset       = 1'b1;
        run         = 1'b0;
        stage_en    = '0;
        man_done    = '0;
        auto_en     = 1'b0;
        stage_we    = '0;
        stage_addr  = '0;
        stage_wdata = '0;
        cyc();
        test_reset();
        test_all_stages();
        test_skip_stage();
        test_zero_mask();
        test_mux();
        test_spurious();
        test_reset_mid_run();
        test_watchdog();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
